// File: rtl/arb_req_agent.sv
// Requester-side client for a fixed-priority arbiter lane.
// It queues {start data, length} jobs in a small FIFO and requests the arbiter.
// After a grant it emits a burst of incrementing data beats, advancing only in
// granted cycles. After each burst it drops the request for one cycle.
module arb_req_agent #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic [LEN_W-1:0]           push_len_i,
  output logic                       req_o,
  input  logic                       gnt_i,
  output logic                       out_valid_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       out_last_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [LEN_W-1:0]  mem_len  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [LEN_W-1:0]  beat_cnt_reg;
  logic [DATA_W-1:0] cur_data_reg;
  logic [DATA_W-1:0] last_data_reg;

  logic push_fire, pop_fire, beat_fire;

  // Ready depends on the registered count only, so a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  assign push_ready_o = (count_reg < CNT_W'(DEPTH));
  assign push_fire    = push_valid_i & push_ready_o;
  assign pop_fire     = (state_reg == REQ) & gnt_i;
  assign beat_fire    = (state_reg == XFER) & gnt_i;

  // Job storage: no reset needed, entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_data[wr_ptr_reg] <= push_data_i;
      mem_len[wr_ptr_reg]  <= push_len_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode: request while work is queued, leave a one-cycle gap after each burst.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (count_reg != '0) state_next = REQ;
      REQ:  if (gnt_i) state_next = XFER;
      XFER: if (gnt_i && (beat_cnt_reg == '0)) state_next = GAP;
      GAP:  state_next = (count_reg != '0) ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Burst datapath: load the FIFO head on grant, advance only on granted beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt_reg  <= '0;
      cur_data_reg  <= '0;
      last_data_reg <= '0;
    end else if (pop_fire) begin
      beat_cnt_reg <= mem_len[rd_ptr_reg];
      cur_data_reg <= mem_data[rd_ptr_reg];
    end else if (beat_fire) begin
      beat_cnt_reg  <= beat_cnt_reg - LEN_W'(1);
      cur_data_reg  <= cur_data_reg + DATA_W'(1);
      last_data_reg <= cur_data_reg;
    end
  end

  // Outputs: beat data follows the working register in XFER and otherwise
  // holds the last emitted beat.
  always_comb begin
    req_o        = (state_reg == REQ) || (state_reg == XFER);
    out_valid_o  = beat_fire;
    out_last_o   = beat_fire && (beat_cnt_reg == '0);
    out_data_o   = (state_reg == XFER) ? cur_data_reg : last_data_reg;
    busy_o       = (state_reg != IDLE);
    fifo_count_o = count_reg;
  end

endmodule

// File: doc/arb_req_agent.md
Name: arb_req_agent

Overview:
- Requester-side client for the 4-way fixed-priority arbiter; one instance per requester lane.
- Queues local transfer jobs in a small FIFO and raises a request to the arbiter.
- Once granted, emits a burst of incrementing-data beats, only in cycles where the grant is present.
- Drops the request for one cycle after every burst so the arbiter can re-evaluate.

Parameters:
- DATA_W, 8, beat data width.
- LEN_W, 4, job length field width; burst beats = len+1, so 1..16 at default.
- DEPTH, 4, job FIFO entries (power of two, >=2).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- push_valid_i  input  1  job offered.
- push_ready_o  output  1  FIFO can accept a job.
- push_data_i  input  DATA_W  start data value of the job.
- push_len_i  input  LEN_W  beats minus one.
- req_o  output  1  request to arbiter (one bit of its req_i).
- gnt_i  input  1  grant from arbiter (matching bit of its gnt_o).
- out_valid_o  output  1  beat valid this cycle.
- out_data_o  output  DATA_W  beat data.
- out_last_o  output  1  final beat of the burst.
- busy_o  output  1  state != IDLE.
- fifo_count_o  output  $clog2(DEPTH+1)  jobs queued.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, FIFO empty, fifo_count_o=0, push_ready_o=1.
  - req_o=0, out_valid_o=0, out_last_o=0, out_data_o=0, busy_o=0.
- Reset mid-burst discards the burst and all queued jobs; no further beats are emitted.
- FIFO:
  - Push accepted at the edge where push_valid_i & push_ready_o.
  - push_ready_o = (count < DEPTH), computed from registered count only. When full, a push is refused even if a pop occurs in the same cycle.
  - Pop occurs on the REQ->XFER transition; the head {data,len} loads into the working registers.
  - Simultaneous push and pop with count not full: count unchanged, order preserved.
  - Pointers wrap mod DEPTH.
- FSM states: IDLE, REQ, XFER, GAP. req_o is decoded from the registered state: req_o = (REQ or XFER).
  - IDLE: if count != 0, go to REQ at next edge. A push accepted at edge k gives req_o=1 from edge k+1. gnt_i is ignored.
  - REQ: hold req_o. When gnt_i=1 is sampled at an edge, pop the FIFO, load beat_cnt=len and cur_data=data, and go to XFER.
  - XFER:
    - out_valid_o = gnt_i (combinational AND with state==XFER); out_data_o = cur_data.
    - On each edge with gnt_i=1: cur_data += 1 (wraps mod 2^DATA_W) and beat_cnt -= 1.
    - out_last_o = out_valid_o & (beat_cnt==0). When the last beat is accepted, go to GAP.
    - gnt_i=0 in XFER (grant stolen by a higher-priority lane) stalls the burst: no beat, counters hold, req_o stays 1, no abort.
  - GAP: req_o=0 for exactly one cycle. Then go to REQ if count != 0, else IDLE. gnt_i is ignored.
- Outside XFER, out_valid_o and out_last_o are 0 and out_data_o holds its last value.
- First beat appears in the cycle after the edge where gnt_i was sampled high in REQ.
- len=0 gives a single beat with out_last_o=1 on it.
- No downstream backpressure exists; a beat is consumed whenever out_valid_o=1.

Test Plan:
- Reset, then push {data=8'h10,len=2} with gnt_i tied 1:
  - req_o rises one cycle after the push.
  - Beats 10,11,12 appear on consecutive cycles, last on 12.
  - req_o is low for exactly 1 cycle, then IDLE with busy_o=0.
- Push 4 jobs back-to-back while gnt_i=0:
  - fifo_count_o=4 and push_ready_o=0; a fifth push is refused.
  - After granting, jobs drain in order with a 1-cycle req_o gap between bursts.
- Burst {data=8'hFE,len=3} with gnt_i pattern 1,0,0,1,1,1:
  - Beats FE,FF,00,01, with out_valid_o=0 during the 2 stall cycles.
  - req_o stays 1 throughout the stall; last on 01.
- Full FIFO with a pop and a push offered in the same cycle: the push is refused; count goes 4->3.
- len=0 job: one beat with out_valid_o=1 and out_last_o=1 together, then GAP.
- Assert reset during beat 2 of a len=5 burst:
  - All outputs return to reset values immediately.
  - After release, nothing is emitted until a new push.
